// File: rtl/scoreboard_register_file_if.sv
// Read/write/reserve bundle of the scoreboard register file.
// The master drives addresses, writes and reservations; the slave returns data and scoreboard status.
interface scoreboard_register_file_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    address1;
    logic [AW-1:0]    address2;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic             busy1;
    logic             busy2;
    logic             write;
    logic [AW-1:0]    writeAddress;
    logic [WIDTH-1:0] writeData;
    logic             write2;
    logic [AW-1:0]    writeAddress2;
    logic [WIDTH-1:0] writeData2;
    logic             reserve;
    logic [AW-1:0]    reserveAddress;
    logic             stall;
    logic [AW:0]      busyCount;

    modport master (
        output address1, address2, write, writeAddress, writeData,
               write2, writeAddress2, writeData2, reserve, reserveAddress,
        input  data1, data2, busy1, busy2, stall, busyCount
    );

    modport slave (
        input  address1, address2, write, writeAddress, writeData,
               write2, writeAddress2, writeData2, reserve, reserveAddress,
        output data1, data2, busy1, busy2, stall, busyCount
    );
endinterface

// File: rtl/scoreboard_register_file.sv
// Two-read / two-write register file with a per-register busy scoreboard.
// Reads bypass same-cycle writes; a write retires the pending producer of its register.
module scoreboard_register_file #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int ZERO_REG = 0
) (
    input  logic                      i_clock,
    input  logic                      i_reset_n,
    scoreboard_register_file_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam bit ZR = (ZERO_REG != 0);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_busy;
    logic [AW:0]      r_busy_cnt;

    logic             w_wa_en;
    logic             w_wb_en;
    logic             w_res_en;
    logic             w_res_ok;
    logic [DEPTH-1:0] w_clr;
    logic [DEPTH-1:0] w_set;
    logic [DEPTH-1:0] w_busy_nxt;
    logic [AW:0]      w_cnt_nxt;

    // Port B is dropped when port A hits the same register; register 0 is immutable when hardwired.
    assign w_wa_en  = bus.write  && !(ZR && bus.writeAddress  == '0);
    assign w_wb_en  = bus.write2 && !(ZR && bus.writeAddress2 == '0)
                      && !(w_wa_en && bus.writeAddress2 == bus.writeAddress);
    assign w_res_en = bus.reserve && !(ZR && bus.reserveAddress == '0);
    assign w_res_ok = w_res_en && (!r_busy[bus.reserveAddress] || w_clr[bus.reserveAddress]);

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
        logic w_hit_a;
        logic w_hit_b;

        assign w_hit_a   = w_wa_en && bus.writeAddress  == AW'(gi);
        assign w_hit_b   = w_wb_en && bus.writeAddress2 == AW'(gi);
        assign w_clr[gi] = w_hit_a || w_hit_b;
        assign w_set[gi] = w_res_ok && bus.reserveAddress == AW'(gi);

        always_ff @(posedge i_clock or negedge i_reset_n) begin
            if (!i_reset_n) begin
                r_mem[gi] <= '0;
            end else if (w_hit_a) begin
                r_mem[gi] <= bus.writeData;
            end else if (w_hit_b) begin
                r_mem[gi] <= bus.writeData2;
            end
        end
    end

    // A reservation landing with a write leaves the register busy: the new producer wins.
    assign w_busy_nxt = (r_busy & ~w_clr) | w_set;

    always_comb begin
        w_cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_cnt_nxt = w_cnt_nxt + (AW+1)'(w_busy_nxt[i]);
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_busy_cnt <= w_cnt_nxt;
        end
    end

    function automatic logic [WIDTH-1:0] f_read(input logic [AW-1:0] a);
        if (!i_reset_n || (ZR && a == '0)) return '0;
        if (w_wa_en && bus.writeAddress == a) return bus.writeData;
        if (w_wb_en && bus.writeAddress2 == a) return bus.writeData2;
        return r_mem[a];
    endfunction

    assign bus.data1     = f_read(bus.address1);
    assign bus.data2     = f_read(bus.address2);
    assign bus.busy1     = i_reset_n && r_busy[bus.address1] && !w_clr[bus.address1];
    assign bus.busy2     = i_reset_n && r_busy[bus.address2] && !w_clr[bus.address2];
    assign bus.stall     = i_reset_n && w_res_en && r_busy[bus.reserveAddress]
                           && !w_clr[bus.reserveAddress];
    assign bus.busyCount = r_busy_cnt;
endmodule

// File: tb/tb_scoreboard_register_file.sv
// Bench for scoreboard_register_file: two instances (ZERO_REG 0 and 1) share one stimulus
// stream and are compared against a per-register array model of data and pending producers.
module tb_scoreboard_register_file;
    localparam int W  = 16;
    localparam int D  = 8;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic [AW-1:0] a1, a2, wa, wa2, ra;
    logic          we, we2, res;
    logic [W-1:0]  wd, wd2;

    scoreboard_register_file_if #(.WIDTH(W), .DEPTH(D)) bus0 ();
    scoreboard_register_file_if #(.WIDTH(W), .DEPTH(D)) bus1 ();

    scoreboard_register_file #(.WIDTH(W), .DEPTH(D), .ZERO_REG(0)) u_dut0 (
        .i_clock(clk), .i_reset_n(rstn), .bus(bus0));
    scoreboard_register_file #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1)) u_dut1 (
        .i_clock(clk), .i_reset_n(rstn), .bus(bus1));

    assign bus0.address1 = a1;  assign bus1.address1 = a1;
    assign bus0.address2 = a2;  assign bus1.address2 = a2;
    assign bus0.write = we;     assign bus1.write = we;
    assign bus0.writeAddress = wa;   assign bus1.writeAddress = wa;
    assign bus0.writeData = wd;      assign bus1.writeData = wd;
    assign bus0.write2 = we2;        assign bus1.write2 = we2;
    assign bus0.writeAddress2 = wa2; assign bus1.writeAddress2 = wa2;
    assign bus0.writeData2 = wd2;    assign bus1.writeData2 = wd2;
    assign bus0.reserve = res;       assign bus1.reserve = res;
    assign bus0.reserveAddress = ra; assign bus1.reserveAddress = ra;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    endtask

    // Reference model: stored value and "producer pending" flag per register, per instance.
    logic [W-1:0] m_mem  [2][D];
    bit           m_busy [2][D];

    function automatic bit m_zero(int z, int a);
        return z == 1 && a == 0;
    endfunction

    function automatic bit m_wr(int z, int a);
        return ((we && int'(wa) == a) || (we2 && int'(wa2) == a)) && !m_zero(z, a);
    endfunction

    function automatic logic [W-1:0] m_data(int z, int a);
        if (!rstn || m_zero(z, a)) return '0;
        if (we && int'(wa) == a) return wd;
        if (we2 && int'(wa2) == a) return wd2;
        return m_mem[z][a];
    endfunction

    function automatic bit m_busyo(int z, int a);
        return rstn && m_busy[z][a] && !m_wr(z, a);
    endfunction

    function automatic bit m_stall(int z);
        return rstn && res && !m_zero(z, int'(ra)) && m_busy[z][ra] && !m_wr(z, int'(ra));
    endfunction

    function automatic int m_count(int z);
        int n = 0;
        for (int i = 0; i < D; i++) n += int'(m_busy[z][i]);
        return n;
    endfunction

    task automatic m_reset();
        for (int z = 0; z < 2; z++)
            for (int i = 0; i < D; i++) begin
                m_mem[z][i]  = '0;
                m_busy[z][i] = 1'b0;
            end
    endtask

    task automatic m_edge();
        if (!rstn) return;
        for (int z = 0; z < 2; z++) begin
            bit acc;
            acc = res && !m_zero(z, int'(ra)) && (!m_busy[z][ra] || m_wr(z, int'(ra)));
            if (we && !m_zero(z, int'(wa))) m_mem[z][wa] = wd;
            if (we2 && !(we && wa == wa2) && !m_zero(z, int'(wa2))) m_mem[z][wa2] = wd2;
            for (int i = 0; i < D; i++) if (m_wr(z, i)) m_busy[z][i] = 1'b0;
            if (acc) m_busy[z][ra] = 1'b1;
        end
    endtask

    task automatic chk_inst(input int z, input logic [W-1:0] d1, input logic [W-1:0] d2,
                            input logic b1, input logic b2, input logic st, input logic [AW:0] bc);
        chk($sformatf("z%0d_data1", z), d1, m_data(z, int'(a1)));
        chk($sformatf("z%0d_data2", z), d2, m_data(z, int'(a2)));
        chk($sformatf("z%0d_busy1", z), b1, m_busyo(z, int'(a1)));
        chk($sformatf("z%0d_busy2", z), b2, m_busyo(z, int'(a2)));
        chk($sformatf("z%0d_stall", z), st, m_stall(z));
        chk($sformatf("z%0d_count", z), bc, m_count(z));
    endtask

    task automatic check_all();
        chk_inst(0, bus0.data1, bus0.data2, bus0.busy1, bus0.busy2, bus0.stall, bus0.busyCount);
        chk_inst(1, bus1.data1, bus1.data2, bus1.busy1, bus1.busy2, bus1.stall, bus1.busyCount);
    endtask

    // Inputs are driven just after a rising edge; outputs are checked at the falling edge.
    task automatic cyc();
        @(negedge clk);
        check_all();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic idle();
        we = 0; we2 = 0; res = 0;
        wa = '0; wa2 = '0; ra = '0; wd = '0; wd2 = '0;
    endtask

    initial begin
        rstn = 1'b1;
        idle();
        a1 = '0; a2 = '0;
        m_reset();
        #2 rstn = 1'b0;
        #1 check_all();
        chk("rst_count", bus0.busyCount, 0);
        cyc();
        cyc();
        rstn = 1'b1;

        for (int i = 0; i < D; i++) begin
            idle(); we = 1; wa = AW'(i); wd = W'(1) << i;
            cyc();
        end
        idle();
        for (int i = 0; i < D; i++) begin
            a1 = AW'(i); a2 = AW'(D - 1 - i);
            #1 chk("wr_rd_a", bus0.data1, 32'(W'(1) << i));
            chk("wr_rd_b", bus0.data2, 32'(W'(1) << (D - 1 - i)));
            cyc();
        end
        chk("wr_count", bus0.busyCount, 0);

        idle(); we = 1; wa = 3; wd = 16'hAAAA; we2 = 1; wa2 = 3; wd2 = 16'h5555; a1 = 3;
        #1 chk("prio_byp", bus0.data1, 16'hAAAA);
        cyc();
        idle(); a1 = 3;
        #1 chk("prio_st", bus0.data1, 16'hAAAA);

        idle(); res = 1; ra = 5; a1 = 5;
        cyc();
        res = 0;
        #1 chk("rsv_busy", bus0.busy1, 1);
        chk("rsv_cnt1", bus0.busyCount, 1);
        res = 1;
        #1 chk("rsv_stall", bus0.stall, 1);
        cyc();
        res = 0;
        #1 chk("rsv_cnt_hold", bus0.busyCount, 1);
        we = 1; wa = 5; wd = 16'h1234;
        #1 chk("ret_byp", bus0.data1, 16'h1234);
        chk("ret_busy", bus0.busy1, 0);
        cyc();
        idle();
        #1 chk("ret_cnt", bus0.busyCount, 0);

        idle(); res = 1; ra = 2; we = 1; wa = 2; wd = 16'hBEEF;
        cyc();
        idle(); a1 = 2;
        #1 chk("rw_busy", bus0.busy1, 1);
        chk("rw_cnt", bus0.busyCount, 1);
        chk("rw_data", bus0.data1, 16'hBEEF);
        we = 1; wa = 2; wd = 16'h0002;
        cyc();

        idle(); we = 1; wa = 0; wd = 16'hFFFF; res = 1; ra = 0; a1 = 0;
        #1 chk("zr_data", bus1.data1, 0);
        chk("zr_busy", bus1.busy1, 0);
        chk("zr_stall", bus1.stall, 0);
        cyc();
        idle(); a1 = 0;
        #1 chk("zr_data_st", bus1.data1, 0);
        chk("zr_cnt", bus1.busyCount, 0);

        foreach (ra[i]) ;
        for (int k = 0; k < 3; k++) begin
            idle(); res = 1; ra = (k == 0) ? 3'd1 : (k == 1) ? 3'd4 : 3'd6;
            cyc();
        end
        idle(); a1 = 1; a2 = 4;
        #2 rstn = 1'b0;
        we = 1; wa = 1; wd = 16'h0077; res = 1; ra = 3;
        m_reset();
        #1 check_all();
        chk("mid_rst_cnt", bus0.busyCount, 0);
        chk("mid_rst_data", bus0.data1, 0);
        cyc();
        rstn = 1'b1;
        idle(); a1 = 1; a2 = 4;
        #1 chk("post_rst_d1", bus0.data1, 0);
        chk("post_rst_cnt", bus0.busyCount, 0);
        cyc();

        repeat (400) begin
            a1  = AW'($urandom);  a2  = AW'($urandom);
            we  = ($urandom_range(0, 9) < 4); wa  = AW'($urandom); wd  = W'($urandom);
            we2 = ($urandom_range(0, 9) < 4); wa2 = AW'($urandom); wd2 = W'($urandom);
            res = ($urandom_range(0, 1) == 1); ra = AW'($urandom);
            if (!rstn) rstn = 1'b1;
            else if ($urandom_range(0, 60) == 0) begin
                rstn = 1'b0;
                m_reset();
            end
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/scoreboard_register_file.md
SCOREBOARD_REGISTER_FILE -- requirements
Module: scoreboard_register_file

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the data bits per register.
REQ-002 Parameter DEPTH, default 8, SHALL set the register count (power of two, 2..256); AW = log2(DEPTH), derived.
REQ-003 Parameter ZERO_REG, default 0, SHALL hardwire register 0 to zero when 1.
REQ-004 clock  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  in  1  SHALL be an asynchronous, active-low reset.
REQ-006 address1, address2  in  AW  SHALL be the read-port addresses.
REQ-007 data1, data2  out  WIDTH  SHALL be the combinational read data.
REQ-008 busy1, busy2  out  1  SHALL be the scoreboard status of address1/address2.
REQ-009 write, writeAddress (AW), writeData (WIDTH)  in  SHALL form write port A.
REQ-010 write2, writeAddress2 (AW), writeData2 (WIDTH)  in  SHALL form write port B.
REQ-011 reserve  in  1, reserveAddress  in  AW  SHALL request marking a register busy (pending producer).
REQ-012 stall  out  1  SHALL flag a refused reservation.
REQ-013 busyCount  out  AW+1  SHALL give the number of busy registers.

Function
REQ-014 Write SHALL occur on the rising clock edge for each enabled port; 1-cycle latency into storage.
REQ-015 Both ports enabled, same address: port A SHALL win; port B discarded.
REQ-016 Read SHALL be combinational with bypass: if a port writes addressN this cycle, dataN SHALL equal that port's data (port A over port B), else stored value.
REQ-017 ZERO_REG=1: address 0 SHALL read 0, ignore writes, never be busy, and stall SHALL stay 0 for reserveAddress 0.
REQ-018 An enabled write to a register SHALL clear its busy bit at that edge.
REQ-019 reserve with target not busy (or busy but cleared by a write this cycle) SHALL set the busy bit at the edge; stall=0.
REQ-020 reserve with target busy and not cleared this cycle SHALL NOT change state; stall=1 combinationally in that cycle.
REQ-021 Reserve and write to same address in the same cycle SHALL leave busy=1 (new producer wins).
REQ-022 busyN SHALL be busy[addressN] AND NOT (write on either port to addressN this cycle), consistent with REQ-016.
REQ-023 busyCount SHALL update at the edge: +1 per accepted set, -1 per clear of a set bit; never over DEPTH or under 0.
REQ-024 Writes to a non-busy register SHALL be legal and SHALL NOT alter busyCount.
REQ-025 stall SHALL be 0 whenever reserve=0.

Reset
REQ-026 reset low SHALL immediately clear all registers to 0, all busy bits to 0, busyCount to 0, independent of clock.
REQ-027 While reset low, writes and reservations SHALL be ignored; data1/data2 SHALL read 0 (bypass disabled).
REQ-028 Reset asserted mid-operation SHALL discard any write or reservation pending in that cycle; first update occurs on the first rising edge after release.

Verification
REQ-029 Write 16'h0001<<i to register i (i=0..7) via port A, then read all on both ports -> data equals written values; busyCount=0.
REQ-030 Same cycle: write=1 addr 3 data 16'hAAAA, write2=1 addr 3 data 16'h5555, address1=3 -> data1=16'hAAAA during cycle and after edge.
REQ-031 reserve addr 5 -> busy1=1 (address1=5), busyCount=1; reserve addr 5 again -> stall=1, busyCount stays 1; write addr 5 data 16'h1234 -> busy cleared, busyCount=0, data1=16'h1234 in same cycle.
REQ-032 Same cycle reserve addr 2 and write addr 2 -> after edge busy=1, busyCount=1, register 2 holds written data.
REQ-033 ZERO_REG=1: write 16'hFFFF to addr 0, reserve addr 0 -> data1=0, busy1=0, stall=0, busyCount=0.
REQ-034 Reserve addrs 1,4,6, then drop reset low between clock edges -> all outputs 0 immediately; after release reads 0, busyCount=0.
